// File: rtl/quad_cordic_pkg.sv
// Shared definitions for the cordic sharing arbiter: data width, cordic latency
// and the arbiter FSM state encoding.
package quad_cordic_pkg;

  localparam int CRD_W      = 24;
  localparam int ITERATIONS = 14;
  localparam int CRD_LAT    = ITERATIONS + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N. Returns a one-hot grant and the matching binary index.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  int slot;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    grant = '0;
    idx   = '0;
    found = 1'b0;
    slot  = 0;
    for (int i = 0; i < N; i++) begin
      slot = int'(ptr) + i;
      if (slot >= N) slot = slot - N;
      if (!found && req[slot]) begin
        grant[slot] = 1'b1;
        idx         = IW'(slot);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one vector-mode cordic among NUM_REQ requesters with round-robin grants,
// returns each result to its owner, and times out a cordic that never finishes.
module cordic_arbiter
  import quad_cordic_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DW      = CRD_W,
  parameter int TIMEOUT = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_x,
  input  logic [NUM_REQ*DW-1:0] req_y,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_angle,
  output logic [DW-1:0]         rsp_magnitude,
  output logic                  rsp_err,
  output logic                  err_sticky,
  output logic                  busy,
  output logic                  crd_start,
  output logic [DW-1:0]         crd_x,
  output logic [DW-1:0]         crd_y,
  input  logic                  crd_done,
  input  logic [DW-1:0]         crd_angle,
  input  logic [DW-1:0]         crd_magnitude
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  // The watchdog must outlast a healthy cordic or every result would be a timeout.
  if (TIMEOUT <= CRD_LAT) begin : g_timeout_check
    $error("TIMEOUT must exceed the cordic latency");
  end

  arb_state_t           state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        owner;
  logic [CW-1:0]        wait_cnt;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IW-1:0]        pick_idx;
  logic                 pick_found;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      wait_cnt      <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_angle     <= '0;
      rsp_magnitude <= '0;
      rsp_err       <= 1'b0;
      err_sticky    <= 1'b0;
      busy          <= 1'b0;
      crd_start     <= 1'b0;
      crd_x         <= '0;
      crd_y         <= '0;
    end else begin
      // NOTE: non-blocking assignments only, so every register samples pre-edge values.
      req_ready <= '0;
      rsp_valid <= '0;
      crd_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            crd_x     <= req_x[pick_idx*DW +: DW];
            crd_y     <= req_y[pick_idx*DW +: DW];
            owner     <= pick_idx;
            req_ready <= pick_grant;
            crd_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // A real completion takes priority over a watchdog expiring in the same cycle.
          if (crd_done) begin
            rsp_angle     <= crd_angle;
            rsp_magnitude <= crd_magnitude;
            rsp_err       <= 1'b0;
            rsp_valid     <= NUM_REQ'(1) << owner;
            state         <= RESP;
          end else if (wait_cnt == CW'(TIMEOUT)) begin
            rsp_angle     <= '0;
            rsp_magnitude <= '0;
            rsp_err       <= 1'b1;
            err_sticky    <= 1'b1;
            rsp_valid     <= NUM_REQ'(1) << owner;
            state         <= RESP;
          end
        end
        RESP: begin
          rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
